// File: rtl/sr_cmd_driver_if.sv
// Command handshake into sr_cmd_driver: the source offers cmd_op with cmd_valid,
// and the driver accepts it on any edge where cmd_ready is also high.
interface sr_cmd_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// Buffers set/clear/toggle commands and turns each one into an en+s or en+r pulse
// for a downstream SR flip-flop, keeping a shadow of its state so s=r=1 never occurs.
module sr_cmd_driver #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic           clk,
  input  logic           reset,
  sr_cmd_driver_if.slave cmd,
  output logic           s,
  output logic           r,
  output logic           en,
  output logic           q_shadow,
  output logic           busy,
  output logic [7:0]     cmd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] PLS_LOAD = PW'(PULSE_LEN);
  localparam logic [PW-1:0] PLS_ONE  = PW'(1);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;

  // IDLE: pop head | DRIVE: pulse counter running | GAP: one quiet cycle, then commit
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [1:0]      fifo_q [DEPTH];
  logic [1:0]      fifo_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            pol_q, pol_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            en_q, en_d;
  logic            q_shadow_q, q_shadow_d;
  logic            busy_q, busy_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [7:0]      cmd_count_q, cmd_count_d;
  logic            push;
  logic            pop;
  logic [1:0]      head;

  always_comb begin
    push        = cmd.cmd_valid && cmd_ready_q;
    pop         = (state_q == IDLE) && (count_q != '0);
    head        = fifo_q[rd_ptr_q];
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    pol_d       = pol_q;
    q_shadow_d  = q_shadow_q;
    cmd_count_d = cmd_count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = cmd.cmd_op;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (pop && (head != OP_NOP)) begin
          state_d = DRIVE;
          pcnt_d  = PLS_LOAD;
          case (head)
            OP_SET:  pol_d = 1'b1;
            OP_CLR:  pol_d = 1'b0;
            default: pol_d = !q_shadow_q;
          endcase
        end
      end
      DRIVE: begin
        if (pcnt_q == PLS_ONE) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q - PLS_ONE;
        end
      end
      GAP: begin
        state_d     = IDLE;
        q_shadow_d  = pol_q;
        cmd_count_d = cmd_count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs trail the state by one edge, so en covers the DRIVE span shifted by one.
    en_d        = (state_q == DRIVE);
    s_d         = en_d && pol_q;
    r_d         = en_d && !pol_q;
    busy_d      = (state_d != IDLE) || (count_d != '0);
    cmd_ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pcnt_q      <= '0;
      pol_q       <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      en_q        <= 1'b0;
      q_shadow_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pcnt_q      <= pcnt_d;
      pol_q       <= pol_d;
      s_q         <= s_d;
      r_q         <= r_d;
      en_q        <= en_d;
      q_shadow_q  <= q_shadow_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign s             = s_q;
  assign r             = r_q;
  assign en            = en_q;
  assign q_shadow      = q_shadow_q;
  assign busy          = busy_q;
  assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: three instances (PULSE_LEN 1, 8, 4) share clk/reset,
// each followed by a behavioural SR flip-flop.
module tb_sr_cmd_driver;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] CLR = 2'b01;
  localparam logic [1:0] SET = 2'b10;
  localparam logic [1:0] TGL = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  int              checks   = 0;
  int              failures = 0;
  logic [2:0]      vld;
  logic [2:0][1:0] op;
  logic [2:0]      rdy, s_o, r_o, en_o, qs_o, busy_o, ff_q;
  logic [2:0][7:0] cnt_o;

  sr_cmd_driver_if if_p1 ();
  sr_cmd_driver_if if_p8 ();
  sr_cmd_driver_if if_p4 ();

  assign if_p1.cmd_valid = vld[0];
  assign if_p1.cmd_op    = op[0];
  assign rdy[0]          = if_p1.cmd_ready;
  assign if_p8.cmd_valid = vld[1];
  assign if_p8.cmd_op    = op[1];
  assign rdy[1]          = if_p8.cmd_ready;
  assign if_p4.cmd_valid = vld[2];
  assign if_p4.cmd_op    = op[2];
  assign rdy[2]          = if_p4.cmd_ready;

  sr_cmd_driver #(.DEPTH(4), .PULSE_LEN(1)) u_p1 (
    .clk(clk), .reset(reset), .cmd(if_p1), .s(s_o[0]), .r(r_o[0]), .en(en_o[0]),
    .q_shadow(qs_o[0]), .busy(busy_o[0]), .cmd_count(cnt_o[0]));
  sr_cmd_driver #(.DEPTH(4), .PULSE_LEN(8)) u_p8 (
    .clk(clk), .reset(reset), .cmd(if_p8), .s(s_o[1]), .r(r_o[1]), .en(en_o[1]),
    .q_shadow(qs_o[1]), .busy(busy_o[1]), .cmd_count(cnt_o[1]));
  sr_cmd_driver #(.DEPTH(4), .PULSE_LEN(4)) u_p4 (
    .clk(clk), .reset(reset), .cmd(if_p4), .s(s_o[2]), .r(r_o[2]), .en(en_o[2]),
    .q_shadow(qs_o[2]), .busy(busy_o[2]), .cmd_count(cnt_o[2]));

  // Downstream SR flip-flops driven by each instance.
  always @(posedge clk)
    ff_q <= reset ? 3'b000 : ((ff_q | (en_o & s_o)) & ~(en_o & r_o));

  // Pulse log for the selected instance, plus s/r invariants on all three.
  int   mon_sel  = 0;
  int   cyc      = 0;
  int   inv_viol = 0;
  bit   pulses[$];
  int   rises[$];
  logic en_prev  = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (((s_o & r_o) != 3'b000) || (((s_o | r_o) & ~en_o) != 3'b000)) inv_viol++;
    if (en_o[mon_sel] && !en_prev) begin
      pulses.push_back(s_o[mon_sel]);
      rises.push_back(cyc);
    end
    en_prev = en_o[mon_sel];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vld   = 3'b000;
    step();
    step();
    reset = 1'b0;
    step();
    pulses.delete();
    rises.delete();
  endtask

  task automatic push(input int sel, input logic [1:0] o, output int waited);
    waited   = 0;
    vld[sel] = 1'b1;
    op[sel]  = o;
    while (!rdy[sel] && waited < 200) begin
      step();
      waited++;
    end
    step();
    vld[sel] = 1'b0;
  endtask

  task automatic wait_idle(input int sel, output int n);
    n = 0;
    while (busy_o[sel] && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld   = 3'b000;
    op    = '0;
    step();
    step();
    checks++;
    if (rdy !== 3'b000) begin failures++; $display("FAIL ready_in_reset got=%b exp=000", rdy); end
    reset = 1'b0;
    step();
    checks++;
    if ({s_o, r_o, en_o} !== 9'd0) begin failures++; $display("FAIL reset_sren got=%b exp=0", {s_o, r_o, en_o}); end
    checks++;
    if (qs_o !== 3'b000) begin failures++; $display("FAIL reset_qshadow got=%b exp=000", qs_o); end
    checks++;
    if (cnt_o !== 24'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", cnt_o); end
    checks++;
    if (rdy !== 3'b111) begin failures++; $display("FAIL ready_after_reset got=%b exp=111", rdy); end
    checks++;
    if (busy_o !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", busy_o); end
  endtask

  task automatic test_set_single();
    int w;
    do_reset();
    mon_sel = 0;
    push(0, SET, w);
    checks++;
    if ({busy_o[0], en_o[0]} !== 2'b10) begin failures++; $display("FAIL set_k busy,en got=%b exp=10", {busy_o[0], en_o[0]}); end
    step();
    checks++;
    if (en_o[0] !== 1'b0) begin failures++; $display("FAIL set_k1_en got=%b exp=0", en_o[0]); end
    step();
    checks++;
    if ({en_o[0], s_o[0], r_o[0]} !== 3'b110) begin failures++; $display("FAIL set_k2_pulse got=%b exp=110", {en_o[0], s_o[0], r_o[0]}); end
    step();
    checks++;
    if ({en_o[0], s_o[0], r_o[0]} !== 3'b000) begin failures++; $display("FAIL set_k3_pulse got=%b exp=000", {en_o[0], s_o[0], r_o[0]}); end
    checks++;
    if ({qs_o[0], busy_o[0], ff_q[0]} !== 3'b101) begin failures++; $display("FAIL set_k3 qs,busy,ff got=%b exp=101", {qs_o[0], busy_o[0], ff_q[0]}); end
    checks++;
    if (cnt_o[0] !== 8'd1) begin failures++; $display("FAIL set_count got=%0d exp=1", cnt_o[0]); end
  endtask

  task automatic test_toggle_queue();
    int w, n;
    do_reset();
    mon_sel = 0;
    for (int i = 0; i < 3; i++) push(0, TGL, w);
    wait_idle(0, n);
    checks++;
    if (n >= 300) begin failures++; $display("FAIL toggle_idle_timeout got=%0d exp=<300", n); end
    checks++;
    if (pulses.size() != 3) begin
      failures++; $display("FAIL toggle_pulse_count got=%0d exp=3", pulses.size());
    end else begin
      checks++;
      if ({pulses[0], pulses[1], pulses[2]} !== 3'b101) begin
        failures++; $display("FAIL toggle_order got=%b exp=101", {pulses[0], pulses[1], pulses[2]});
      end
      checks++;
      if ((rises[1] - rises[0] != 3) || (rises[2] - rises[1] != 3)) begin
        failures++; $display("FAIL toggle_spacing got=%0d,%0d exp=3,3", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    checks++;
    if ({qs_o[0], ff_q[0]} !== 2'b11) begin failures++; $display("FAIL toggle_final qs,ff got=%b exp=11", {qs_o[0], ff_q[0]}); end
    checks++;
    if (cnt_o[0] !== 8'd3) begin failures++; $display("FAIL toggle_count got=%0d exp=3", cnt_o[0]); end
  endtask

  task automatic test_fifo_full();
    int w, n;
    logic [5:0] got;
    do_reset();
    mon_sel = 1;
    push(1, SET, w);
    step();
    step();
    push(1, CLR, w);
    push(1, SET, w);
    push(1, CLR, w);
    push(1, CLR, w);
    checks++;
    if (rdy[1] !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", rdy[1]); end
    push(1, TGL, w);
    checks++;
    if (w != 5) begin failures++; $display("FAIL full_hold_cycles got=%0d exp=5", w); end
    wait_idle(1, n);
    checks++;
    if (n >= 300) begin failures++; $display("FAIL full_idle_timeout got=%0d exp=<300", n); end
    checks++;
    if (pulses.size() != 6) begin
      failures++; $display("FAIL full_pulse_count got=%0d exp=6", pulses.size());
    end else begin
      for (int i = 0; i < 6; i++) got[5-i] = pulses[i];
      checks++;
      if (got !== 6'b101001) begin failures++; $display("FAIL full_order got=%b exp=101001", got); end
    end
    checks++;
    if ({cnt_o[1], qs_o[1], ff_q[1]} !== {8'd6, 2'b11}) begin
      failures++; $display("FAIL full_final cnt=%0d qs=%b ff=%b exp cnt=6 qs=1 ff=1", cnt_o[1], qs_o[1], ff_q[1]);
    end
  endtask

  task automatic test_nop_drop();
    int w, n;
    do_reset();
    mon_sel = 0;
    push(0, NOP, w);
    push(0, CLR, w);
    push(0, NOP, w);
    wait_idle(0, n);
    checks++;
    if (n != 3) begin failures++; $display("FAIL nop_busy_drop got=%0d exp=3", n); end
    checks++;
    if (pulses.size() != 1) begin
      failures++; $display("FAIL nop_pulse_count got=%0d exp=1", pulses.size());
    end else begin
      checks++;
      if (pulses[0] !== 1'b0) begin failures++; $display("FAIL nop_pulse_kind got=%b exp=0", pulses[0]); end
    end
    checks++;
    if ({cnt_o[0], qs_o[0], ff_q[0]} !== {8'd1, 2'b00}) begin
      failures++; $display("FAIL nop_final cnt=%0d qs=%b ff=%b exp cnt=1 qs=0 ff=0", cnt_o[0], qs_o[0], ff_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    mon_sel = 2;
    push(2, SET, w);
    push(2, SET, w);
    step();
    step();
    checks++;
    if ({en_o[2], s_o[2]} !== 2'b11) begin failures++; $display("FAIL mid_second_drive got=%b exp=11", {en_o[2], s_o[2]}); end
    reset = 1'b1;
    step();
    checks++;
    if ({en_o[2], s_o[2], r_o[2], qs_o[2], busy_o[2], rdy[2]} !== 6'd0) begin
      failures++; $display("FAIL mid_abort got=%b exp=000000", {en_o[2], s_o[2], r_o[2], qs_o[2], busy_o[2], rdy[2]});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({rdy[2], busy_o[2]} !== 2'b10) begin failures++; $display("FAIL mid_fifo_empty rdy,busy got=%b exp=10", {rdy[2], busy_o[2]}); end
    pulses.delete();
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pulses.size() != 0) begin failures++; $display("FAIL mid_residual_pulses got=%0d exp=0", pulses.size()); end
    checks++;
    if ({cnt_o[2], qs_o[2], ff_q[2]} !== 10'd0) begin
      failures++; $display("FAIL mid_final cnt=%0d qs=%b ff=%b exp all 0", cnt_o[2], qs_o[2], ff_q[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vld   = 3'b000;
    op    = '0;
    test_reset();
    test_set_single();
    test_toggle_queue();
    test_fifo_full();
    test_nop_drop();
    test_reset_mid();
    checks++;
    if (inv_viol != 0) begin failures++; $display("FAIL sr_invariant got=%0d exp=0", inv_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
